// File: rtl/arbiter_rr_lock_if.sv
// Handshake bundle between the router datapath and the packet-locking arbiter.
// The arbiter connects to the slave modport; the routing/crossbar side uses master.
interface arbiter_rr_lock_if #(
  parameter int unsigned NUM_PORTS = 7
);
  logic [NUM_PORTS-1:0]           reqs;
  logic [NUM_PORTS*NUM_PORTS-1:0] route_fwd;
  logic [NUM_PORTS-1:0]           fifo_available;
  logic                           xfer;
  logic                           xfer_tail;
  logic [NUM_PORTS-1:0]           grants;
  logic [NUM_PORTS-1:0]           forwards;
  logic                           locked;
  logic                           abort_pulse;

  modport master (
    output reqs, route_fwd, fifo_available, xfer, xfer_tail,
    input  grants, forwards, locked, abort_pulse
  );

  modport slave (
    input  reqs, route_fwd, fifo_available, xfer, xfer_tail,
    output grants, forwards, locked, abort_pulse
  );
endinterface

// File: rtl/arbiter_rr_lock.sv
// Packet-granular crossbar arbiter: grants one input, holds the grant until a
// tail flit moves or the request drops, with fixed or round-robin selection.
module arbiter_rr_lock #(
  parameter int unsigned NUM_PORTS = 7,
  parameter int unsigned ARB_MODE  = 1
) (
  input logic               clk,
  input logic               rst,
  arbiter_rr_lock_if.slave  bus
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic [NUM_PORTS-1:0] grants_r;
  logic [NUM_PORTS-1:0] forwards_r;
  logic                 abort_r;

  logic [NUM_PORTS-1:0] eligible;
  logic                 pick_valid;
  logic [PTR_W-1:0]     pick_idx;
  logic [NUM_PORTS-1:0] pick_oh;
  logic [NUM_PORTS-1:0] pick_route;
  logic                 req_held;
  logic                 tail_release;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = bus.reqs[i] &
                    (|(bus.route_fwd[i*NUM_PORTS +: NUM_PORTS] & bus.fifo_available));
    end
  end

  // Scan starts at rr_ptr in round-robin mode, at 0 in fixed mode; first hit wins.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    pick_route = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = (ARB_MODE == 1) ? ((int'(rr_ptr) + k) % NUM_PORTS) : k;
      if (!pick_valid && eligible[idx]) begin
        pick_valid   = 1'b1;
        pick_idx     = PTR_W'(idx);
        pick_oh      = '0;
        pick_oh[idx] = 1'b1;
        pick_route   = bus.route_fwd[idx*NUM_PORTS +: NUM_PORTS] & bus.fifo_available;
      end
    end
  end

  assign req_held     = |(bus.reqs & grants_r);
  assign tail_release = bus.xfer & bus.xfer_tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grants_r   <= '0;
      forwards_r <= '0;
      abort_r    <= 1'b0;
      rr_ptr     <= '0;
      grant_idx  <= '0;
    end else begin
      abort_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= LOCKED;
            grants_r   <= pick_oh;
            forwards_r <= pick_route;
            grant_idx  <= pick_idx;
          end else begin
            grants_r   <= '0;
            forwards_r <= '0;
          end
        end
        LOCKED: begin
          if (tail_release || !req_held) begin
            state      <= IDLE;
            grants_r   <= '0;
            forwards_r <= '0;
            // A tail flit in the same cycle as the request drop is a clean end.
            abort_r    <= !bus.xfer_tail;
            if (ARB_MODE == 1) begin
              if (int'(grant_idx) == NUM_PORTS - 1) rr_ptr <= '0;
              else                                  rr_ptr <= grant_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grants      = grants_r;
  assign bus.forwards    = forwards_r;
  assign bus.locked      = (state == LOCKED);
  assign bus.abort_pulse = abort_r;

endmodule

// File: tb/tb_arbiter_rr_lock.sv
// Scoreboard bench for arbiter_rr_lock: a fixed-priority and a round-robin
// instance share stimulus; a behavioural model queues expected outputs per cycle.
module tb_arbiter_rr_lock;

  localparam int unsigned N = 7;

  typedef struct packed {
    logic [N-1:0] g;
    logic [N-1:0] f;
    logic         lk;
    logic         ab;
    logic [2:0]   ptr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   reqs;
  logic [N*N-1:0] route_fwd;
  logic [N-1:0]   fifo_available;
  logic           xfer;
  logic           xfer_tail;

  always #5 clk = ~clk;

  arbiter_rr_lock_if #(.NUM_PORTS(N)) bus_fx ();
  arbiter_rr_lock_if #(.NUM_PORTS(N)) bus_rr ();

  assign bus_fx.reqs           = reqs;
  assign bus_fx.route_fwd      = route_fwd;
  assign bus_fx.fifo_available = fifo_available;
  assign bus_fx.xfer           = xfer;
  assign bus_fx.xfer_tail      = xfer_tail;
  assign bus_rr.reqs           = reqs;
  assign bus_rr.route_fwd      = route_fwd;
  assign bus_rr.fifo_available = fifo_available;
  assign bus_rr.xfer           = xfer;
  assign bus_rr.xfer_tail      = xfer_tail;

  arbiter_rr_lock #(.NUM_PORTS(N), .ARB_MODE(0)) dut_fx (.clk(clk), .rst(rst), .bus(bus_fx));
  arbiter_rr_lock #(.NUM_PORTS(N), .ARB_MODE(1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q_exp[$];

  // Model state, index = ARB_MODE (0 fixed, 1 round-robin).
  logic         m_lk  [2];
  int           m_gi  [2];
  logic [N-1:0] m_g   [2];
  logic [N-1:0] m_f   [2];
  logic         m_ab  [2];
  int           m_ptr [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic elig(input int i);
    logic [N-1:0] sl;
    sl = route_fwd[i*N +: N];
    return reqs[i] && ((sl & fifo_available) != '0);
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      exp_t e;
      if (rst) begin
        m_lk[m] = 1'b0; m_gi[m] = 0; m_g[m] = '0; m_f[m] = '0;
        m_ab[m] = 1'b0; m_ptr[m] = 0;
      end else begin
        m_ab[m] = 1'b0;
        if (!m_lk[m]) begin
          int pick;
          pick = -1;
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m == 1) ? (m_ptr[m] + k) % N : k;
            if (pick < 0 && elig(i)) pick = i;
          end
          if (pick >= 0) begin
            m_lk[m] = 1'b1;
            m_gi[m] = pick;
            m_g[m]  = '0;
            m_g[m][pick] = 1'b1;
            m_f[m]  = route_fwd[pick*N +: N] & fifo_available;
          end else begin
            m_g[m] = '0;
            m_f[m] = '0;
          end
        end else if ((xfer && xfer_tail) || !reqs[m_gi[m]]) begin
          m_ab[m] = !reqs[m_gi[m]] && !xfer_tail;
          m_lk[m] = 1'b0;
          m_g[m]  = '0;
          m_f[m]  = '0;
          if (m == 1) m_ptr[m] = (m_gi[m] + 1) % N;
        end
      end
      e.g = m_g[m]; e.f = m_f[m]; e.lk = m_lk[m]; e.ab = m_ab[m]; e.ptr = 3'(m_ptr[m]);
      q_exp.push_back(e);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N*N-1:0] rt,
                      input logic [N-1:0] fa, input logic x, input logic xt, input logic rs);
    exp_t e;
    reqs = r; route_fwd = rt; fifo_available = fa; xfer = x; xfer_tail = xt; rst = rs;
    model_step();
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    check("fx_grants",   32'(bus_fx.grants),      32'(e.g));
    check("fx_forwards", 32'(bus_fx.forwards),    32'(e.f));
    check("fx_locked",   32'(bus_fx.locked),      32'(e.lk));
    check("fx_abort",    32'(bus_fx.abort_pulse), 32'(e.ab));
    check("fx_rr_ptr",   32'(dut_fx.rr_ptr),      32'(e.ptr));
    e = q_exp.pop_front();
    check("rr_grants",   32'(bus_rr.grants),      32'(e.g));
    check("rr_forwards", 32'(bus_rr.forwards),    32'(e.f));
    check("rr_locked",   32'(bus_rr.locked),      32'(e.lk));
    check("rr_abort",    32'(bus_rr.abort_pulse), 32'(e.ab));
    check("rr_rr_ptr",   32'(dut_rr.rr_ptr),      32'(e.ptr));
  endtask

  function automatic logic [N*N-1:0] set_route(input logic [N*N-1:0] base, input int i, input int o);
    logic [N*N-1:0] r;
    r = base;
    r[i*N +: N] = '0;
    r[i*N + o]  = 1'b1;
    return r;
  endfunction

  function automatic logic [N*N-1:0] all_to(input int o);
    logic [N*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = set_route(r, i, o);
    return r;
  endfunction

  initial begin
    logic [N*N-1:0] rt;
    logic [N-1:0]   ones;
    ones = '1;
    reqs = '0; route_fwd = '0; fifo_available = '0; xfer = 1'b0; xfer_tail = 1'b0; rst = 1'b1;

    // Reset state
    step('0, '0, ones, 1'b0, 1'b0, 1'b1);
    check("reset_grants", 32'(bus_rr.grants), 32'h0);
    check("reset_locked", 32'(bus_rr.locked), 32'h0);

    // Fixed priority, all routes to output 0
    step(7'b0010110, all_to(0), ones, 1'b0, 1'b0, 1'b0);
    check("fixed_grants",   32'(bus_fx.grants),   32'h02);
    check("fixed_forwards", 32'(bus_fx.forwards), 32'h01);
    check("fixed_locked",   32'(bus_fx.locked),   32'h1);
    step(7'b0010110, all_to(0), ones, 1'b1, 1'b1, 1'b0);

    // Round-robin alternation between inputs 1 and 4
    step('0, '0, ones, 1'b0, 1'b0, 1'b1);
    rt = set_route(set_route('0, 1, 0), 4, 2);
    step(7'b0010010, rt, ones, 1'b0, 1'b0, 1'b0);
    check("rr_seq0", 32'(bus_rr.grants), 32'h02);
    step(7'b0010010, rt, ones, 1'b1, 1'b1, 1'b0);
    check("rr_seq1", 32'(bus_rr.grants), 32'h00);
    step(7'b0010010, rt, ones, 1'b0, 1'b0, 1'b0);
    check("rr_seq2", 32'(bus_rr.grants), 32'h10);
    step(7'b0010010, rt, ones, 1'b1, 1'b1, 1'b0);
    check("rr_seq3", 32'(bus_rr.grants), 32'h00);
    step(7'b0010010, rt, ones, 1'b0, 1'b0, 1'b0);
    check("rr_seq4", 32'(bus_rr.grants), 32'h02);
    step(7'b0010010, rt, ones, 1'b1, 1'b1, 1'b0);

    // Downstream FIFO full blocks eligibility
    step('0, '0, ones, 1'b0, 1'b0, 1'b1);
    rt = set_route('0, 2, 3);
    step(7'b0000100, rt, 7'b1110111, 1'b0, 1'b0, 1'b0);
    step(7'b0000100, rt, 7'b1110111, 1'b0, 1'b0, 1'b0);
    check("blocked_grants", 32'(bus_rr.grants), 32'h00);
    step(7'b0000100, rt, ones, 1'b0, 1'b0, 1'b0);
    check("unblocked_grants",   32'(bus_rr.grants),   32'h04);
    check("unblocked_forwards", 32'(bus_rr.forwards), 32'h08);
    step(7'b0000100, rt, ones, 1'b1, 1'b1, 1'b0);

    // Lock on input 5 holds through unrelated activity
    step('0, '0, ones, 1'b0, 1'b0, 1'b1);
    rt = set_route(all_to(1), 5, 6);
    step(7'b0100000, rt, ones, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(7'(($urandom | 32'h20)), rt, 7'($urandom), 1'(k[0]), 1'b0, 1'b0);
      check("hold_grants", 32'(bus_fx.grants), 32'h20);
    end
    step(7'b0100000, rt, '0, 1'b1, 1'b1, 1'b0);
    check("hold_release", 32'(bus_fx.grants), 32'h00);

    // Request drop without tail aborts the packet
    step('0, '0, ones, 1'b0, 1'b0, 1'b1);
    rt = set_route('0, 3, 1);
    step(7'b0001000, rt, ones, 1'b0, 1'b0, 1'b0);
    step('0, rt, ones, 1'b0, 1'b0, 1'b0);
    check("abort_pulse",  32'(bus_rr.abort_pulse), 32'h1);
    check("abort_locked", 32'(bus_rr.locked),      32'h0);
    check("abort_rr_ptr", 32'(dut_rr.rr_ptr),      32'h4);
    step('0, rt, ones, 1'b1, 1'b0, 1'b0);
    check("abort_oneshot", 32'(bus_rr.abort_pulse), 32'h0);

    // Drop coinciding with tail is a clean end
    step(7'b0001000, rt, ones, 1'b0, 1'b0, 1'b0);
    step('0, rt, ones, 1'b1, 1'b1, 1'b0);
    check("tail_wins_abort", 32'(bus_rr.abort_pulse), 32'h0);

    // Multi-hot route masked by FIFO availability at grant
    step('0, '0, ones, 1'b0, 1'b0, 1'b1);
    rt = '0;
    rt[0*N +: N] = 7'b0110000;
    step(7'b0000001, rt, 7'b0100001, 1'b0, 1'b0, 1'b0);
    check("multihot_fwd", 32'(bus_fx.forwards), 32'h20);
    step(7'b0000001, rt, 7'b0100001, 1'b1, 1'b1, 1'b0);

    // Reset mid-packet, then round-robin restarts from index 0
    rt = all_to(0);
    step(7'b0000100, rt, ones, 1'b0, 1'b0, 1'b0);
    step(7'b0000100, rt, ones, 1'b1, 1'b1, 1'b0);
    step(7'b0100000, rt, ones, 1'b0, 1'b0, 1'b0);
    step(7'b0100000, rt, ones, 1'b1, 1'b1, 1'b1);
    check("rst_grants",  32'(bus_rr.grants), 32'h00);
    check("rst_locked",  32'(bus_rr.locked), 32'h0);
    check("rst_rr_ptr",  32'(dut_rr.rr_ptr), 32'h0);
    step(7'b0010010, rt, ones, 1'b0, 1'b0, 1'b0);
    check("post_rst_grant", 32'(bus_rr.grants), 32'h02);
    step(7'b0010010, rt, ones, 1'b1, 1'b1, 1'b0);

    // xfer while idle has no effect
    step('0, rt, ones, 1'b1, 1'b1, 1'b0);
    check("idle_xfer", 32'(bus_rr.locked), 32'h0);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [N*N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
        r = set_route(r, i, int'($urandom_range(N - 1)));
        if ($urandom_range(7) == 0) r[i*N + int'($urandom_range(N - 1))] = 1'b1;
      end
      step(7'(~($urandom & $urandom)) & 7'($urandom | $urandom), r,
           7'(~($urandom & $urandom)), 1'($urandom), ($urandom_range(3) == 0),
           ($urandom_range(39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
